// File: rtl/dmem_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port data memory.
// One access at a time: IDLE -> ACCESS -> RESP, with registered read data per requester.
module dmem_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_BITS  = 5
) (
    input  logic                  clock,
    input  logic                  reset_n,

    input  logic                  req0,
    input  logic                  we0,
    input  logic [31:0]           addr0,
    input  logic [DATA_WIDTH-1:0] wdata0,
    output logic                  ack0,
    output logic [DATA_WIDTH-1:0] rdata0,

    input  logic                  req1,
    input  logic                  we1,
    input  logic [31:0]           addr1,
    input  logic [DATA_WIDTH-1:0] wdata1,
    output logic                  ack1,
    output logic [DATA_WIDTH-1:0] rdata1,

    output logic [31:0]           mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  mem_write,
    input  logic [DATA_WIDTH-1:0] mem_rdata,

    output logic                  busy,
    output logic                  grant_id
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic                  gnt_q, gnt_d;
    logic                  last_gnt_q, last_gnt_d;
    logic                  ack0_q, ack0_d;
    logic                  ack1_q, ack1_d;
    logic [DATA_WIDTH-1:0] rdata0_q, rdata0_d;
    logic [DATA_WIDTH-1:0] rdata1_q, rdata1_d;

    // Signals of the requester currently granted.
    logic                  we_g;
    logic [ADDR_BITS-1:0]  addr_g;
    logic [DATA_WIDTH-1:0] wdata_g;
    logic                  req_other;

    assign we_g      = gnt_q ? we1 : we0;
    assign addr_g    = gnt_q ? addr1[ADDR_BITS-1:0] : addr0[ADDR_BITS-1:0];
    assign wdata_g   = gnt_q ? wdata1 : wdata0;
    assign req_other = gnt_q ? req0 : req1;

    // Address bits above ADDR_BITS are deliberately ignored (aliasing).
    logic unused_addr_bits;
    assign unused_addr_bits = ^{addr0[31:ADDR_BITS], addr1[31:ADDR_BITS]};

    // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        last_gnt_d = last_gnt_q;
        ack0_d     = 1'b0;
        ack1_d     = 1'b0;
        rdata0_d   = rdata0_q;
        rdata1_d   = rdata1_q;
        mem_addr   = '0;
        mem_wdata  = '0;
        mem_write  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (req0 || req1) begin
                    state_d = S_ACCESS;
                    gnt_d   = (req0 && req1) ? ~last_gnt_q : req1;
                end
            end
            S_ACCESS: begin
                mem_addr   = {{(32-ADDR_BITS){1'b0}}, addr_g};
                mem_wdata  = wdata_g;
                mem_write  = we_g;
                last_gnt_d = gnt_q;
                state_d    = S_RESP;
                if (gnt_q) begin
                    ack1_d = 1'b1;
                    if (!we_g) rdata1_d = mem_rdata;
                end else begin
                    ack0_d = 1'b1;
                    if (!we_g) rdata0_d = mem_rdata;
                end
            end
            S_RESP: begin
                // The requester just acked is ignored here, which gives strict alternation.
                if (req_other) begin
                    gnt_d   = ~gnt_q;
                    state_d = S_ACCESS;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            gnt_q      <= 1'b0;
            last_gnt_q <= 1'b1;
            ack0_q     <= 1'b0;
            ack1_q     <= 1'b0;
            rdata0_q   <= '0;
            rdata1_q   <= '0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            last_gnt_q <= last_gnt_d;
            ack0_q     <= ack0_d;
            ack1_q     <= ack1_d;
            rdata0_q   <= rdata0_d;
            rdata1_q   <= rdata1_d;
        end
    end

    assign ack0     = ack0_q;
    assign ack1     = ack1_q;
    assign rdata0   = rdata0_q;
    assign rdata1   = rdata1_q;
    assign busy     = (state_q != S_IDLE);
    assign grant_id = gnt_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural 32x32 memory attached.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_dmem_arbiter;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        req0, we0, req1, we1;
    logic [31:0] addr0, addr1, wdata0, wdata1;
    logic        ack0, ack1;
    logic [31:0] rdata0, rdata1;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_write;
    logic        busy, grant_id;

    logic [31:0] mem [32];

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    dmem_arbiter #(.DATA_WIDTH(32), .ADDR_BITS(5)) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .req0     (req0),
        .we0      (we0),
        .addr0    (addr0),
        .wdata0   (wdata0),
        .ack0     (ack0),
        .rdata0   (rdata0),
        .req1     (req1),
        .we1      (we1),
        .addr1    (addr1),
        .wdata1   (wdata1),
        .ack1     (ack1),
        .rdata1   (rdata1),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_write(mem_write),
        .mem_rdata(mem_rdata),
        .busy     (busy),
        .grant_id (grant_id)
    );

    // External memory model: combinational read, write on rising edge.
    assign mem_rdata = mem[mem_addr[4:0]];
    always @(posedge clock) if (mem_write) mem[mem_addr[4:0]] <= mem_wdata;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input int id, input logic r, input logic w,
                         input logic [31:0] a, input logic [31:0] d);
        if (id == 0) begin
            req0 = r; we0 = w; addr0 = a; wdata0 = d;
        end else begin
            req1 = r; we1 = w; addr1 = a; wdata1 = d;
        end
    endtask

    // One isolated access from IDLE: ACCESS one cycle later, ack the cycle after.
    task automatic single(input int id, input logic w, input logic [31:0] a,
                          input logic [31:0] d, input logic [31:0] exp_rd);
        drive(id, 1'b1, w, a, d);
        step();
        check("acc_mem_write", 32'(mem_write), 32'(w));
        check("acc_mem_addr", mem_addr, {27'd0, a[4:0]});
        check("acc_busy", 32'(busy), 32'd1);
        check("acc_grant", 32'(grant_id), 32'(id));
        check("acc_no_ack", {30'd0, ack1, ack0}, 32'd0);
        if (w) check("acc_mem_wdata", mem_wdata, d);
        step();
        check("resp_ack", {30'd0, ack1, ack0}, (id == 0) ? 32'd1 : 32'd2);
        check("resp_mem_write", 32'(mem_write), 32'd0);
        if (!w) check("resp_rdata", (id == 0) ? rdata0 : rdata1, exp_rd);
        drive(id, 1'b0, 1'b0, 32'd0, 32'd0);
        step();
        check("after_idle_busy", 32'(busy), 32'd0);
        check("after_no_ack", {30'd0, ack1, ack0}, 32'd0);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        repeat (3) step();
        reset_n = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = 32'h01010101 * i;
        req0 = 0; we0 = 0; addr0 = 0; wdata0 = 0;
        req1 = 0; we1 = 0; addr1 = 0; wdata1 = 0;

        // Reset then idle.
        do_reset();
        check("rst_ack", {30'd0, ack1, ack0}, 32'd0);
        check("rst_rdata0", rdata0, 32'd0);
        check("rst_rdata1", rdata1, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_grant", 32'(grant_id), 32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("idle_mem_write", 32'(mem_write), 32'd0);
            check("idle_mem_addr", mem_addr, 32'd0);
            check("idle_busy", 32'(busy), 32'd0);
        end

        // Simultaneous requests from reset: requester 0 first, then 1.
        do_reset();
        drive(0, 1'b1, 1'b0, 32'd3, 32'd0);
        drive(1, 1'b1, 1'b1, 32'd3, 32'h12345678);
        step();
        check("sim_acc0_grant", 32'(grant_id), 32'd0);
        check("sim_acc0_write", 32'(mem_write), 32'd0);
        check("sim_acc0_addr", mem_addr, 32'd3);
        step();
        check("sim_ack0", {30'd0, ack1, ack0}, 32'd1);
        check("sim_rdata0_old", rdata0, 32'h03030303);
        drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
        step();
        check("sim_acc1_grant", 32'(grant_id), 32'd1);
        check("sim_acc1_write", 32'(mem_write), 32'd1);
        check("sim_acc1_wdata", mem_wdata, 32'h12345678);
        check("sim_acc1_no_ack", {30'd0, ack1, ack0}, 32'd0);
        step();
        check("sim_ack1", {30'd0, ack1, ack0}, 32'd2);
        check("sim_rdata0_held", rdata0, 32'h03030303);
        drive(1, 1'b0, 1'b0, 32'd0, 32'd0);
        step();
        check("sim_idle", 32'(busy), 32'd0);
        single(0, 1'b0, 32'd3, 32'd0, 32'h12345678);

        // Single write then read by requester 1.
        single(1, 1'b1, 32'd5, 32'hDEADBEEF, 32'd0);
        single(1, 1'b0, 32'd5, 32'd0, 32'hDEADBEEF);

        // Fairness: last served was 1, so 1 loses the first tie.
        drive(0, 1'b1, 1'b0, 32'd10, 32'd0);
        drive(1, 1'b1, 1'b0, 32'd11, 32'd0);
        for (int k = 1; k <= 20; k++) begin
            step();
            if (k % 2 == 0) begin
                check("fair_ack", {30'd0, ack1, ack0}, ((k / 2) % 2 == 1) ? 32'd1 : 32'd2);
                if ((k / 2) % 2 == 1) check("fair_rdata0", rdata0, 32'h0A0A0A0A);
                else                  check("fair_rdata1", rdata1, 32'h0B0B0B0B);
            end else begin
                check("fair_no_ack", {30'd0, ack1, ack0}, 32'd0);
                check("fair_busy", 32'(busy), 32'd1);
                check("fair_grant", 32'(grant_id), (((k + 1) / 2) % 2 == 1) ? 32'd0 : 32'd1);
            end
        end
        drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
        drive(1, 1'b0, 1'b0, 32'd0, 32'd0);
        step();
        check("fair_end_idle", 32'(busy), 32'd0);

        // Address aliasing: 0x21 lands in word 1.
        single(0, 1'b1, 32'h21, 32'hA5A5A5A5, 32'd0);
        single(1, 1'b0, 32'd1, 32'd0, 32'hA5A5A5A5);
        check("alias_mem_word1", mem[1], 32'hA5A5A5A5);

        // Reset asserted in the middle of a write ACCESS.
        drive(1, 1'b1, 1'b1, 32'd7, 32'h55AA55AA);
        step();
        check("rstmid_write_on", 32'(mem_write), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        check("rstmid_write_drop", 32'(mem_write), 32'd0);
        check("rstmid_busy", 32'(busy), 32'd0);
        step();
        check("rstmid_no_ack", {30'd0, ack1, ack0}, 32'd0);
        check("rstmid_mem_unchanged", mem[7], 32'h07070707);
        drive(1, 1'b0, 1'b0, 32'd0, 32'd0);
        reset_n = 1'b1;
        step();
        check("rstmid_idle", 32'(busy), 32'd0);
        check("rstmid_idle_write", 32'(mem_write), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
